// File: rtl/seg7_pkg.sv
// Shared types, hex font and polarity helpers for the 7-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  // Active-high segment patterns, bit 0 = A ... bit 6 = G.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  // Map an active-high segment vector onto the board's pin level.
  function automatic logic [6:0] seg_level(input logic [6:0] lit, input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

  // Map a single active-high enable onto the board's pin level.
  function automatic logic bit_level(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// 4-bit hex code to active-high 7-segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Font lookup.
  always_comb begin
    seg = HEX_FONT[code];
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment bank driver with LZ blanking, masks, PWM and anti-ghost blank.
// Latency: outputs registered; each edge's outputs reflect the state entered on that edge.
// Backpressure: none; inputs are sampled once per frame at the start of digit 0's slot.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 5,
  parameter int DIV_COUNT        = 8000,
  parameter int BLANK_CYCLES     = 16,
  parameter int BRIGHT_W         = 3,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b0
)
(
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   DisplayGround,
  output logic [6:0]              inputDisplay,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int SLOT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIV_COUNT - 1);
  // Unreachable when BLANK_CYCLES is 0 because BLANK is never entered then.
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam scan_state_t       SLOT_START = (BLANK_CYCLES == 0) ? ON : BLANK;

  // Everything the display shows for one frame, frozen at frame start.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    lz;
    logic [BRIGHT_W-1:0]     bright;
  } frame_t;

  scan_state_t          state, state_nx;
  logic [SLOT_W-1:0]    slot_cnt, slot_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic [BRIGHT_W-1:0]  pwm_cnt, pwm_nx;
  frame_t               frame, frame_nx, frame_in;

  logic [3:0]            cur_code;
  logic                  cur_blank, cur_dp, cur_lz;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic                  pwm_on, drive, seg_lit, dp_lit, gnd_lit;
  logic [NUM_DIGITS-1:0] gnd_onehot;
  logic [6:0]            font_seg, seg_nx;
  logic                  frame_done_nx;

  assign frame_in = '{digits: digits, blank: blank_mask, dp: dp_mask,
                      lz: lz_suppress, bright: brightness};

  // State, counters and shadow registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      slot_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
      frame    <= '0;
    end else begin
      state    <= state_nx;
      slot_cnt <= slot_nx;
      idx      <= idx_nx;
      pwm_cnt  <= pwm_nx;
      frame    <= frame_nx;
    end
  end

  // Next-state: slot sequencing, digit advance and frame capture at digit 0 start.
  always_comb begin
    state_nx = state;
    slot_nx  = slot_cnt;
    idx_nx   = idx;
    pwm_nx   = pwm_cnt;
    frame_nx = frame;
    if (!enable) begin
      state_nx = IDLE;
      slot_nx  = '0;
      idx_nx   = '0;
      pwm_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SLOT_START;
          slot_nx  = '0;
          idx_nx   = '0;
          pwm_nx   = '0;
          frame_nx = frame_in;
        end
        BLANK: begin
          slot_nx = slot_cnt + SLOT_W'(1);
          if (slot_cnt == BLANK_LAST) begin
            state_nx = ON;
          end
        end
        ON: begin
          if (slot_cnt == SLOT_LAST) begin
            state_nx = SLOT_START;
            slot_nx  = '0;
            pwm_nx   = '0;
            if (idx == IDX_LAST) begin
              idx_nx   = '0;
              frame_nx = frame_in;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            slot_nx = slot_cnt + SLOT_W'(1);
            pwm_nx  = pwm_cnt + BRIGHT_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Select the digit being entered and work out whether it is lit.
  always_comb begin
    cur_code   = '0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    zero_run   = 1'b1;
    lz_dark    = '0;
    gnd_onehot = '0;
    // A digit is a leading zero when it and every digit to its left are zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (frame_nx.digits[4*i +: 4] == 4'h0);
      lz_dark[i] = frame_nx.lz & zero_run & (i > 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nx == IDX_W'(i)) begin
        cur_code  = frame_nx.digits[4*i +: 4];
        cur_blank = frame_nx.blank[i];
        cur_dp    = frame_nx.dp[i];
        cur_lz    = lz_dark[i];
      end
    end
    pwm_on  = (&frame_nx.bright) || (pwm_nx < frame_nx.bright);
    drive   = (state_nx == ON) && !cur_blank && pwm_on;
    seg_lit = drive && !cur_lz;
    // A suppressed zero may still show its decimal point.
    dp_lit  = drive && cur_dp;
    gnd_lit = seg_lit || dp_lit;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      gnd_onehot[i] = gnd_lit && (idx_nx == IDX_W'(i));
    end
    seg_nx        = seg_lit ? font_seg : 7'h00;
    frame_done_nx = (state_nx == ON) && (slot_nx == SLOT_LAST) && (idx_nx == IDX_LAST);
  end

  seg7_hex_decode u_dec (
    .code (cur_code),
    .seg  (font_seg)
  );

  // Output registers, polarity applied here.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      DisplayGround <= {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
      inputDisplay  <= seg_level(7'h00, SEG_ACTIVE_LOW);
      dp            <= bit_level(1'b0, SEG_ACTIVE_LOW);
      frame_done    <= 1'b0;
    end else begin
      DisplayGround <= gnd_onehot ^ {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
      inputDisplay  <= seg_level(seg_nx, SEG_ACTIVE_LOW);
      dp            <= bit_level(dp_lit, SEG_ACTIVE_LOW);
      frame_done    <= frame_done_nx;
    end
  end

endmodule
